crc_byte_feeder: RTL and testbench

Upstream stage of the CRC32 peripheral: accepts 8/16/32-bit bus writes of message data, unpacks them into a byte circular buffer, and presents bytes one at a time to the CRC engine over a valid/ready handshake. Replaces the single-byte write path so software can push whole words per store. It also provides a per-byte end-of-message marker, an overflow flag and a fill level for software polling.

---
 rtl/crc_byte_feeder.sv | 130 +++++++++++++
 tb/tb_crc_byte_feeder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_byte_feeder.sv
// crc_byte_feeder: unpacks 8/16/32-bit bus writes into a byte circular buffer
// and hands bytes one at a time to the CRC engine over a valid/ready handshake.
module crc_byte_feeder #(
  parameter int unsigned DEPTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [1:0]               wr_size,
  input  logic [31:0]              wr_data,
  input  logic                     wr_last,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic                     byte_valid,
  output logic [7:0]               byte_data,
  output logic                     byte_last,
  input  logic                     byte_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [8:0]    mem_q [DEPTH];
  logic [8:0]    mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [2:0]    n_bytes;
  logic [CW-1:0] free_space;
  logic          wr_req;
  logic          push;
  logic          reject;
  logic          pop;

  // Decode write size into a byte count and judge space on the pre-pop count.
  always_comb begin
    n_bytes = 3'd0;
    unique case (wr_size)
      2'b00:   n_bytes = 3'd1;
      2'b01:   n_bytes = 3'd2;
      2'b10:   n_bytes = 3'd4;
      default: n_bytes = 3'd0;
    endcase
    free_space = CW'(DEPTH) - count_q;
    wr_ready   = (free_space >= CW'(n_bytes));
    wr_req     = wr_en && (wr_size != 2'b11);
    push       = wr_req && wr_ready && !flush;
    reject     = wr_req && !wr_ready;
    pop        = (count_q != '0) && byte_ready && !flush;
  end

  // Scatter the accepted write bytes into the ring starting at wr_ptr.
  always_comb begin
    int sel;
    logic [AW-1:0] idx;
    sel = 0;
    idx = '0;
    mem_d = mem_q;
    if (push) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(n_bytes)) begin
          sel = MSB_FIRST ? (int'(n_bytes) - 1 - k) : k;
          idx = wr_ptr_q + AW'(k);
          mem_d[idx] = {wr_last && (k == int'(n_bytes) - 1), wr_data[8*sel +: 8]};
        end
      end
    end
  end

  // Pointer, count and sticky overflow next-state; flush overrides push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(n_bytes);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (push ? CW'(n_bytes) : '0) - (pop ? CW'(1) : '0);
    end
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    // A rejected write beats a coincident clear.
    if (reject) begin
      ovf_d = 1'b1;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Byte storage; contents are don't-care after reset so it is not reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign byte_valid = (count_q != '0);
  assign byte_data  = mem_q[rd_ptr_q][7:0];
  assign byte_last  = mem_q[rd_ptr_q][8];
  assign level      = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_crc_byte_feeder.sv
// Directed bench for crc_byte_feeder: LSB-first instance for the main flow,
// MSB-first instance for byte-order reversal.
module tb_crc_byte_feeder;

  logic        clk;
  logic        rst_n;
  logic        wr_en, wr_last, flush, byte_ready, clr_ovf;
  logic [1:0]  wr_size;
  logic [31:0] wr_data;
  logic        wr_ready, byte_valid, byte_last, overflow;
  logic [7:0]  byte_data;
  logic [3:0]  level;

  logic        m_wr_en, m_wr_last, m_flush, m_byte_ready, m_clr_ovf;
  logic [1:0]  m_wr_size;
  logic [31:0] m_wr_data;
  logic        m_wr_ready, m_byte_valid, m_byte_last, m_overflow;
  logic [7:0]  m_byte_data;
  logic [3:0]  m_level;

  int checks   = 0;
  int failures = 0;

  crc_byte_feeder #(.DEPTH(8), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_size(wr_size), .wr_data(wr_data),
    .wr_last(wr_last), .wr_ready(wr_ready), .flush(flush), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  crc_byte_feeder #(.DEPTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .wr_en(m_wr_en), .wr_size(m_wr_size), .wr_data(m_wr_data),
    .wr_last(m_wr_last), .wr_ready(m_wr_ready), .flush(m_flush),
    .byte_valid(m_byte_valid), .byte_data(m_byte_data), .byte_last(m_byte_last),
    .byte_ready(m_byte_ready), .level(m_level), .overflow(m_overflow), .clr_ovf(m_clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle write strobe on the LSB-first instance.
  task automatic push(input logic [1:0] size, input logic [31:0] data, input logic last);
    wr_en   = 1'b1;
    wr_size = size;
    wr_data = data;
    wr_last = last;
    tick();
    wr_en   = 1'b0;
    wr_last = 1'b0;
  endtask

  // Check the head byte, then pop it.
  task automatic pop_expect(input string tag, input logic [7:0] d, input logic l);
    check({tag, "_valid"}, 32'(byte_valid), 32'd1);
    check({tag, "_data"}, 32'(byte_data), 32'(d));
    check({tag, "_last"}, 32'(byte_last), 32'(l));
    byte_ready = 1'b1;
    tick();
    byte_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] seq_a [4];
    logic [7:0] seq_w [7];
    logic [7:0] seq_m [4];
    seq_a = '{8'h11, 8'h22, 8'h33, 8'h44};
    seq_w = '{8'h06, 8'h07, 8'h08, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    seq_m = '{8'h01, 8'h02, 8'h03, 8'h04};

    rst_n = 1'b0; wr_en = 1'b0; wr_size = 2'b00; wr_data = '0; wr_last = 1'b0;
    flush = 1'b0; byte_ready = 1'b0; clr_ovf = 1'b0;
    m_wr_en = 1'b0; m_wr_size = 2'b00; m_wr_data = '0; m_wr_last = 1'b0;
    m_flush = 1'b0; m_byte_ready = 1'b0; m_clr_ovf = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(byte_valid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    for (int s = 0; s < 3; s++) begin
      wr_size = 2'(s);
      #1;
      check("rst_wr_ready", 32'(wr_ready), 32'd1);
    end

    // Popping while empty does nothing
    byte_ready = 1'b1;
    tick();
    check("empty_pop_level", 32'(level), 32'd0);

    // 32-bit write drained at one byte per cycle
    push(2'b10, 32'h44332211, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("w32_level", 32'(level), 32'(4 - i));
      check("w32_data", 32'(byte_data), 32'(seq_a[i]));
      check("w32_last", 32'(byte_last), 32'd0);
      tick();
    end
    check("w32_end_level", 32'(level), 32'd0);
    check("w32_end_valid", 32'(byte_valid), 32'd0);
    byte_ready = 1'b0;

    // 16-bit write with end-of-message on the second byte
    push(2'b01, 32'h0000BBAA, 1'b1);
    check("w16_level", 32'(level), 32'd2);
    pop_expect("w16_b0", 8'hAA, 1'b0);
    check("w16_level_after", 32'(level), 32'd1);
    pop_expect("w16_b1", 8'hBB, 1'b1);

    // Fill to 6, reject a 32-bit write, then top up with 16 bits
    push(2'b10, 32'h04030201, 1'b0);
    push(2'b01, 32'h00000605, 1'b0);
    check("fill6_level", 32'(level), 32'd6);
    wr_size = 2'b10;
    #1;
    check("fill6_wr_ready32", 32'(wr_ready), 32'd0);
    push(2'b10, 32'hEEEEEEEE, 1'b0);
    check("reject_level", 32'(level), 32'd6);
    check("reject_ovf", 32'(overflow), 32'd1);
    push(2'b01, 32'h00000807, 1'b0);
    check("top_level", 32'(level), 32'd8);
    check("top_ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf", 32'(overflow), 32'd0);
    wr_size = 2'b00;
    #1;
    check("full_wr_ready8", 32'(wr_ready), 32'd0);

    // Full buffer rejects even with a coincident pop
    byte_ready = 1'b1;
    push(2'b00, 32'h00000099, 1'b0);
    byte_ready = 1'b0;
    check("fullpop_level", 32'(level), 32'd7);
    check("fullpop_ovf", 32'(overflow), 32'd1);
    check("fullpop_head", 32'(byte_data), 32'h02);
    clr_ovf = 1'b1;
    push(2'b10, 32'h12345678, 1'b0);
    clr_ovf = 1'b0;
    check("set_beats_clr", 32'(overflow), 32'd1);
    check("set_beats_clr_level", 32'(level), 32'd7);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("clr_ovf2", 32'(overflow), 32'd0);

    // Drain to 3, then a write that straddles the pointer wrap
    for (int i = 0; i < 4; i++) begin
      pop_expect("drain", 8'(i + 2), 1'b0);
    end
    check("drain_level", 32'(level), 32'd3);
    push(2'b10, 32'hDDCCBBAA, 1'b0);
    check("wrap_level", 32'(level), 32'd7);
    for (int i = 0; i < 7; i++) begin
      pop_expect("wrap", seq_w[i], 1'b0);
    end
    check("wrap_end_level", 32'(level), 32'd0);

    // Simultaneous push and pop at level 3
    push(2'b00, 32'h00000010, 1'b0);
    push(2'b00, 32'h00000011, 1'b0);
    push(2'b00, 32'h00000012, 1'b0);
    byte_ready = 1'b1;
    push(2'b00, 32'h00000013, 1'b0);
    byte_ready = 1'b0;
    check("pushpop_level", 32'(level), 32'd3);
    pop_expect("pushpop_a", 8'h11, 1'b0);
    pop_expect("pushpop_b", 8'h12, 1'b0);
    pop_expect("pushpop_c", 8'h13, 1'b0);

    // Flush with a coincident write at level 5
    push(2'b10, 32'h24232221, 1'b0);
    push(2'b00, 32'h00000025, 1'b0);
    check("preflush_level", 32'(level), 32'd5);
    flush = 1'b1;
    byte_ready = 1'b1;
    push(2'b00, 32'h00000077, 1'b1);
    flush = 1'b0;
    byte_ready = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_valid", 32'(byte_valid), 32'd0);
    push(2'b00, 32'h00000055, 1'b0);
    check("postflush_level", 32'(level), 32'd1);
    pop_expect("postflush", 8'h55, 1'b0);

    // MSB-first instance: 32-bit write emitted high byte first
    m_byte_ready = 1'b1;
    m_wr_en = 1'b1; m_wr_size = 2'b10; m_wr_data = 32'h01020304; m_wr_last = 1'b1;
    tick();
    m_wr_en = 1'b0; m_wr_last = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("msb_valid", 32'(m_byte_valid), 32'd1);
      check("msb_data", 32'(m_byte_data), 32'(seq_m[i]));
      check("msb_last", 32'(m_byte_last), (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    check("msb_end_valid", 32'(m_byte_valid), 32'd0);
    check("msb_ovf", 32'(m_overflow), 32'd0);
    check("msb_level", 32'(m_level), 32'd0);
    check("msb_wr_ready", 32'(m_wr_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
